calc_core_seq: RTL and testbench
================================

// Module: calc_core_seq
// PURPOSE
//  Parametrised keypad calculator core: hex-digit entry into X, chained binary ops (+,-,*) against Y,
//  square, sign change, and a memory register (MC/MR/M+). Multiply/square use a sequential
//  shift-add multiplier (busy while running). Sits between the keypad decoder (keycode/newkey)
//  and the 7-segment display driver (Xdisplay, LED_NEG_digit, LED_OVW).
// PARAMETERS
//  DIGITS  4  hex digits of operand magnitude; W = 4*DIGITS
//  SAT     0  1: overflowed results saturate to 2^W-1; 0: keep low W bits of magnitude
// PORTS
//  clk            in   1     system clock; single clock domain, all state on rising edge
//  rst            in   1     asynchronous, active-low reset
//  keycode        in   5     key code, valid when newkey=1
//  newkey         in   1     one-cycle key strobe
//  Xdisplay       out  W     magnitude of X
//  LED_NEG_digit  out  1     sign of X (1 = negative)
//  LED_OVW        out  1     sticky overflow flag
//  busy           out  1     multiplier running; keys ignored
//  mem_valid      out  1     memory register holds a non-cleared value
// BEHAVIOUR
//  Keys: digit = keycode[4]==1 (value keycode[3:0]); CA 00100; CE 01100; ADD 01011; SUB 01010;
//   MUL 01001; SQR 00001; CHS 00010; EQ 00011; MC 00101; MR 00110; MPLUS 00111; others ignored.
//  Number format: sign + W-bit magnitude for X, Y, M. -0 never stored (zero forces sign=0).
//  Reset (rst=0, async): X=Y=M=0, signs 0, OP=NONE, ovf=0, busy=0, mem_valid=0, fresh=1, cnt=0.
//  States: IDLE, MULT. All keys with busy=1 are dropped (no queueing).
//  Digit (IDLE): if fresh: X={0..0,d}, sign 0, ndig=1, fresh=0; else if ndig<DIGITS:
//   X={X[W-5:0],d}, ndig++; else ignored (entry limit). Result on Xdisplay next cycle.
//  CE: X=0, sign 0, ovf=0, fresh=1. CA: X=Y=0, OP=NONE, ovf=0, fresh=1 (M kept).
//  CHS: sign^=1 unless X==0. 1-cycle.
//  Op key (ADD/SUB/MUL): if OP!=NONE and fresh==0 -> evaluate Y OP X first (chaining), result to Y;
//   else Y=X. Then OP=new op, fresh=1, X unchanged on display until next digit.
//  EQ: if OP!=NONE -> X = Y OP X, OP=NONE, fresh=1; else no-op.
//  ADD/SUB: signed add of (W+1)-bit signed-magnitude values, result in X (or Y) one cycle after key.
//   SUB computes Y-X. |result| > 2^W-1 sets ovf; stored magnitude per SAT.
//  MUL/SQR: enter MULT, busy=1 from cycle after key for exactly W cycles; radix-2 shift-add over
//   multiplier bits LSB first, 2W-bit accumulator. On exit: magnitude = low W bits (or 2^W-1 if SAT and
//   upper W bits !=0), sign = sA^sB (SQR: 0), ovf |= (upper W bits !=0). busy falls same edge result
//   is written; total latency key->result W+1 cycles. Destination X (EQ/SQR) or Y (chain).
//  MC: M=0, mem_valid=0. MR: X=M, sign_M, fresh=1. MPLUS: M = M + X (signed), mem_valid=1; overflow
//   sets ovf, M saturates/wraps per SAT. All 1-cycle.
//  newkey with an unlisted code: no state change. newkey held >1 cycle = repeated keys.
//  ovf sticky until CE, CA or reset. LED_OVW = ovf.
//  Reset asserted during MULT: abort immediately, all state to reset values.
// TESTING
//  1) DIGITS=4: keys 1,2,3,4,5 -> Xdisplay=0x1234 (5th digit dropped), NEG=0.
//  2) 7, ADD, 5, EQ -> Xdisplay=0x000C one cycle after EQ; 3,SUB,9,EQ -> 0x0006, NEG=1.
//  3) 2,ADD,3,MUL,4,EQ -> chained ((2+3)*4): busy high 16 cycles, Xdisplay=0x0014 at cycle 17.
//  4) FFFF, SQR -> OVW=1, Xdisplay=0x0001 (SAT=0) / 0xFFFF (SAT=1); CE clears OVW and X.
//  5) 5,CHS,MPLUS,3,MPLUS,CA,MR -> Xdisplay=0x0002, NEG=1, mem_valid=1; MC -> mem_valid=0.
//  6) 9,MUL,9,EQ then keys during busy and rst=0 at cycle 5 -> keys ignored; all outputs 0 after reset.

Source files
------------

// File: rtl/calc_core_seq_if.sv
// Keypad-side and display-side signals of the calculator core.
// newkey is a one-cycle strobe with no back-pressure: the core consumes a key on the edge it
// sees newkey=1 unless busy=1, in which case the key is dropped; the outputs are always valid.
interface calc_core_seq_if #(
  parameter int W = 16
);
  logic [4:0]   keycode;
  logic         newkey;
  logic [W-1:0] Xdisplay;
  logic         LED_NEG_digit;
  logic         LED_OVW;
  logic         busy;
  logic         mem_valid;

  modport master (
    output keycode, newkey,
    input  Xdisplay, LED_NEG_digit, LED_OVW, busy, mem_valid
  );

  modport slave (
    input  keycode, newkey,
    output Xdisplay, LED_NEG_digit, LED_OVW, busy, mem_valid
  );
endinterface

// File: rtl/calc_core_seq.sv
// Keypad calculator core: hex entry into X, chained +,-,* against Y, square, sign change and a
// memory register. Multiply and square run on a sequential radix-2 shift-add unit.
module calc_core_seq #(
  parameter int DIGITS = 4,
  parameter bit SAT    = 1'b0
) (
  input  logic           clk,
  input  logic           rst,
  calc_core_seq_if.slave bus,
  output logic           dbg_state_o
);
  localparam int W  = 4 * DIGITS;
  localparam int NW = $clog2(DIGITS + 1);
  localparam int CW = (W > 1) ? $clog2(W) : 1;

  localparam logic [4:0] K_SQR   = 5'b00001;
  localparam logic [4:0] K_CHS   = 5'b00010;
  localparam logic [4:0] K_EQ    = 5'b00011;
  localparam logic [4:0] K_CA    = 5'b00100;
  localparam logic [4:0] K_MC    = 5'b00101;
  localparam logic [4:0] K_MR    = 5'b00110;
  localparam logic [4:0] K_MPLUS = 5'b00111;
  localparam logic [4:0] K_MUL   = 5'b01001;
  localparam logic [4:0] K_SUB   = 5'b01010;
  localparam logic [4:0] K_ADD   = 5'b01011;
  localparam logic [4:0] K_CE    = 5'b01100;

  typedef enum logic { S_IDLE = 1'b0, S_MULT = 1'b1 } state_t;
  typedef enum logic [1:0] { OP_NONE, OP_ADD, OP_SUB, OP_MUL } op_t;
  typedef struct packed {
    logic         s;
    logic [W-1:0] m;
    logic         ovf;
  } num_t;

  // Signed-magnitude add; a zero magnitude always carries a positive sign.
  function automatic num_t sm_add(input logic as, input logic [W-1:0] am,
                                  input logic bs, input logic [W-1:0] bm);
    logic signed [W+1:0] a;
    logic signed [W+1:0] b;
    logic signed [W+1:0] sum;
    logic [W+1:0]        mag;
    num_t                r;
    a     = as ? -$signed({2'b00, am}) : $signed({2'b00, am});
    b     = bs ? -$signed({2'b00, bm}) : $signed({2'b00, bm});
    sum   = a + b;
    mag   = sum[W+1] ? $unsigned(-sum) : $unsigned(sum);
    r.ovf = |mag[W+1:W];
    r.m   = (SAT && r.ovf) ? {W{1'b1}} : mag[W-1:0];
    r.s   = sum[W+1] && (r.m != '0);
    return r;
  endfunction

  function automatic num_t mul_fix(input logic s, input logic [2*W-1:0] p);
    num_t r;
    r.ovf = |p[2*W-1:W];
    r.m   = (SAT && r.ovf) ? {W{1'b1}} : p[W-1:0];
    r.s   = s && (r.m != '0);
    return r;
  endfunction

  state_t         state_q;
  op_t            op_q;
  logic [W-1:0]   x_q, y_q, m_q;
  logic           xs_q, ys_q, ms_q;
  logic           ovf_q, mem_valid_q, fresh_q;
  logic [NW-1:0]  ndig_q;
  logic [CW-1:0]  cnt_q;
  logic [2*W-1:0] acc_q, mcand_q;
  logic [W-1:0]   mplier_q;
  logic           msign_q, mdest_y_q;

  logic [2*W-1:0] acc_d;
  num_t           ev, mp, mres;
  op_t            key_op;

  always_comb begin
    acc_d  = acc_q + (mplier_q[0] ? mcand_q : '0);
    ev     = sm_add(ys_q, y_q, (op_q == OP_SUB) ? ~xs_q : xs_q, x_q);
    mp     = sm_add(ms_q, m_q, xs_q, x_q);
    mres   = mul_fix(msign_q, acc_d);
    key_op = OP_NONE;
    case (bus.keycode)
      K_ADD:   key_op = OP_ADD;
      K_SUB:   key_op = OP_SUB;
      K_MUL:   key_op = OP_MUL;
      default: key_op = OP_NONE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      op_q        <= OP_NONE;
      x_q         <= '0;
      y_q         <= '0;
      m_q         <= '0;
      xs_q        <= 1'b0;
      ys_q        <= 1'b0;
      ms_q        <= 1'b0;
      ovf_q       <= 1'b0;
      mem_valid_q <= 1'b0;
      fresh_q     <= 1'b1;
      ndig_q      <= '0;
      cnt_q       <= '0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      msign_q     <= 1'b0;
      mdest_y_q   <= 1'b0;
    end else if (state_q == S_MULT) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + 1'b1;
      if (cnt_q == CW'(W - 1)) begin
        state_q <= S_IDLE;
        cnt_q   <= '0;
        ovf_q   <= ovf_q | mres.ovf;
        if (mdest_y_q) begin
          y_q  <= mres.m;
          ys_q <= mres.s;
        end else begin
          x_q  <= mres.m;
          xs_q <= mres.s;
        end
      end
    end else if (bus.newkey) begin
      if (bus.keycode[4]) begin
        if (fresh_q) begin
          x_q     <= W'(bus.keycode[3:0]);
          xs_q    <= 1'b0;
          ndig_q  <= NW'(1);
          fresh_q <= 1'b0;
        end else if (ndig_q < NW'(DIGITS)) begin
          x_q    <= (x_q << 4) | W'(bus.keycode[3:0]);
          ndig_q <= ndig_q + 1'b1;
        end
      end else begin
        case (bus.keycode)
          K_CE: begin
            x_q     <= '0;
            xs_q    <= 1'b0;
            ovf_q   <= 1'b0;
            fresh_q <= 1'b1;
          end
          K_CA: begin
            x_q     <= '0;
            xs_q    <= 1'b0;
            y_q     <= '0;
            ys_q    <= 1'b0;
            op_q    <= OP_NONE;
            ovf_q   <= 1'b0;
            fresh_q <= 1'b1;
          end
          K_CHS: if (x_q != '0) xs_q <= ~xs_q;
          K_ADD, K_SUB, K_MUL: begin
            // A pending op with a freshly entered operand is evaluated into Y before the new op.
            if (op_q != OP_NONE && !fresh_q) begin
              if (op_q == OP_MUL) begin
                state_q   <= S_MULT;
                acc_q     <= '0;
                mcand_q   <= {{W{1'b0}}, y_q};
                mplier_q  <= x_q;
                msign_q   <= ys_q ^ xs_q;
                mdest_y_q <= 1'b1;
                cnt_q     <= '0;
              end else begin
                y_q   <= ev.m;
                ys_q  <= ev.s;
                ovf_q <= ovf_q | ev.ovf;
              end
            end else begin
              y_q  <= x_q;
              ys_q <= xs_q;
            end
            op_q    <= key_op;
            fresh_q <= 1'b1;
          end
          K_EQ: if (op_q != OP_NONE) begin
            if (op_q == OP_MUL) begin
              state_q   <= S_MULT;
              acc_q     <= '0;
              mcand_q   <= {{W{1'b0}}, y_q};
              mplier_q  <= x_q;
              msign_q   <= ys_q ^ xs_q;
              mdest_y_q <= 1'b0;
              cnt_q     <= '0;
            end else begin
              x_q   <= ev.m;
              xs_q  <= ev.s;
              ovf_q <= ovf_q | ev.ovf;
            end
            op_q    <= OP_NONE;
            fresh_q <= 1'b1;
          end
          K_SQR: begin
            state_q   <= S_MULT;
            acc_q     <= '0;
            mcand_q   <= {{W{1'b0}}, x_q};
            mplier_q  <= x_q;
            msign_q   <= 1'b0;
            mdest_y_q <= 1'b0;
            cnt_q     <= '0;
            fresh_q   <= 1'b1;
          end
          K_MC: begin
            m_q         <= '0;
            ms_q        <= 1'b0;
            mem_valid_q <= 1'b0;
          end
          K_MR: begin
            x_q     <= m_q;
            xs_q    <= ms_q;
            fresh_q <= 1'b1;
          end
          K_MPLUS: begin
            // The accumulated X is finished with, so the next digit starts a new number.
            m_q         <= mp.m;
            ms_q        <= mp.s;
            ovf_q       <= ovf_q | mp.ovf;
            mem_valid_q <= 1'b1;
            fresh_q     <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.Xdisplay      = x_q;
  assign bus.LED_NEG_digit = xs_q;
  assign bus.LED_OVW       = ovf_q;
  assign bus.busy          = (state_q == S_MULT);
  assign bus.mem_valid     = mem_valid_q;
  assign dbg_state_o       = state_q;
endmodule

// File: tb/tb_calc_core_seq.sv
// Directed bench for calc_core_seq: a table of single-cycle key vectors followed by hand-written
// multiply, square, busy-drop and reset-abort sequences on a wrap and a saturating instance.
module tb_calc_core_seq;
  localparam int W = 16;

  localparam logic [4:0] K_SQR   = 5'b00001;
  localparam logic [4:0] K_CHS   = 5'b00010;
  localparam logic [4:0] K_EQ    = 5'b00011;
  localparam logic [4:0] K_CA    = 5'b00100;
  localparam logic [4:0] K_MC    = 5'b00101;
  localparam logic [4:0] K_MR    = 5'b00110;
  localparam logic [4:0] K_MPLUS = 5'b00111;
  localparam logic [4:0] K_MUL   = 5'b01001;
  localparam logic [4:0] K_SUB   = 5'b01010;
  localparam logic [4:0] K_ADD   = 5'b01011;
  localparam logic [4:0] K_CE    = 5'b01100;

  typedef struct {
    logic [4:0]   key;
    logic [W-1:0] x;
    logic         neg;
    logic         ovf;
    logic         mv;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         dbg0, dbg1;
  int           n_vec = 0;
  int           n_err = 0;
  logic [W-1:0] exp_q[$];
  vec_t         tbl[$];

  calc_core_seq_if #(.W(W)) bus0 ();
  calc_core_seq_if #(.W(W)) bus1 ();

  calc_core_seq #(.DIGITS(4), .SAT(1'b0)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0), .dbg_state_o(dbg0)
  );
  calc_core_seq #(.DIGITS(4), .SAT(1'b1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1), .dbg_state_o(dbg1)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic press(input logic [4:0] k);
    @(negedge clk);
    bus0.keycode = k;
    bus1.keycode = k;
    bus0.newkey  = 1'b1;
    bus1.newkey  = 1'b1;
    @(negedge clk);
    bus0.newkey  = 1'b0;
    bus1.newkey  = 1'b0;
  endtask

  task automatic digits(input logic [W-1:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) press({1'b1, v[4*i +: 4]});
  endtask

  task automatic add(input logic [4:0] k, input logic [W-1:0] x, input logic n,
                     input logic o, input logic m);
    vec_t v;
    v.key = k; v.x = x; v.neg = n; v.ovf = o; v.mv = m;
    tbl.push_back(v);
  endtask

  initial begin
    rst = 1'b0;
    bus0.keycode = '0; bus0.newkey = 1'b0;
    bus1.keycode = '0; bus1.newkey = 1'b0;

    // key, Xdisplay, NEG, OVW, mem_valid after the key
    add(5'h11, 16'h0001, 0, 0, 0); add(5'h12, 16'h0012, 0, 0, 0);
    add(5'h13, 16'h0123, 0, 0, 0); add(5'h14, 16'h1234, 0, 0, 0);
    add(5'h15, 16'h1234, 0, 0, 0); add(K_CE,  16'h0000, 0, 0, 0);
    add(5'h17, 16'h0007, 0, 0, 0); add(K_ADD, 16'h0007, 0, 0, 0);
    add(5'h15, 16'h0005, 0, 0, 0); add(K_EQ,  16'h000C, 0, 0, 0);
    add(5'h13, 16'h0003, 0, 0, 0); add(K_SUB, 16'h0003, 0, 0, 0);
    add(5'h19, 16'h0009, 0, 0, 0); add(K_EQ,  16'h0006, 1, 0, 0);
    add(K_CHS, 16'h0006, 0, 0, 0); add(K_CA,  16'h0000, 0, 0, 0);
    add(K_CHS, 16'h0000, 0, 0, 0); add(5'h15, 16'h0005, 0, 0, 0);
    add(K_CHS, 16'h0005, 1, 0, 0); add(K_MPLUS, 16'h0005, 1, 0, 1);
    add(5'h13, 16'h0003, 0, 0, 1); add(K_MPLUS, 16'h0003, 0, 0, 1);
    add(K_CA,  16'h0000, 0, 0, 1); add(K_MR,  16'h0002, 1, 0, 1);
    add(K_MC,  16'h0002, 1, 0, 0); add(5'h00, 16'h0002, 1, 0, 0);
    add(5'h0D, 16'h0002, 1, 0, 0); add(K_CA,  16'h0000, 0, 0, 0);
    add(5'h18, 16'h0008, 0, 0, 0); add(K_ADD, 16'h0008, 0, 0, 0);
    add(5'h13, 16'h0003, 0, 0, 0); add(K_SUB, 16'h0003, 0, 0, 0);
    add(5'h11, 16'h0001, 0, 0, 0); add(K_EQ,  16'h000A, 0, 0, 0);
    add(K_CA,  16'h0000, 0, 0, 0); add(5'h1F, 16'h000F, 0, 0, 0);
    add(5'h1F, 16'h00FF, 0, 0, 0); add(5'h1F, 16'h0FFF, 0, 0, 0);
    add(5'h1F, 16'hFFFF, 0, 0, 0); add(K_ADD, 16'hFFFF, 0, 0, 0);
    add(5'h11, 16'h0001, 0, 0, 0); add(K_EQ,  16'h0000, 0, 1, 0);
    add(5'h11, 16'h0001, 0, 1, 0); add(K_CE,  16'h0000, 0, 0, 0);

    repeat (3) @(negedge clk);
    check("reset x", bus0.Xdisplay, 0);
    check("reset neg", bus0.LED_NEG_digit, 0);
    check("reset ovw", bus0.LED_OVW, 0);
    check("reset busy", bus0.busy, 0);
    check("reset mem_valid", bus0.mem_valid, 0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < tbl.size(); i++) begin
      exp_q.push_back(tbl[i].x);
      press(tbl[i].key);
      check($sformatf("vec%0d x", i), bus0.Xdisplay, exp_q.pop_front());
      check($sformatf("vec%0d neg", i), bus0.LED_NEG_digit, tbl[i].neg);
      check($sformatf("vec%0d ovw", i), bus0.LED_OVW, tbl[i].ovf);
      check($sformatf("vec%0d mem_valid", i), bus0.mem_valid, tbl[i].mv);
    end

    // (2+3)*4 with the product landing in X
    press(K_CA); digits(16'h2, 1); press(K_ADD); digits(16'h3, 1);
    press(K_MUL); digits(16'h4, 1); press(K_EQ);
    check("chain busy first", bus0.busy, 1);
    check("chain state", dbg0, 1);
    check("chain x during", bus0.Xdisplay, 16'h0004);
    for (int c = 1; c < W; c++) begin
      @(negedge clk);
      check($sformatf("chain busy c%0d", c), bus0.busy, 1);
    end
    @(negedge clk);
    check("chain busy end", bus0.busy, 0);
    check("chain x", bus0.Xdisplay, 16'h0014);
    check("chain neg", bus0.LED_NEG_digit, 0);

    // -3*5 chained into Y, keys during busy dropped, then +1
    press(K_CA); digits(16'h3, 1); press(K_CHS); press(K_MUL); digits(16'h5, 1); press(K_ADD);
    check("ychain busy", bus0.busy, 1);
    press(5'h17); press(K_CHS);
    check("ychain x held", bus0.Xdisplay, 16'h0005);
    check("ychain neg held", bus0.LED_NEG_digit, 0);
    repeat (12) @(negedge clk);
    check("ychain busy end", bus0.busy, 0);
    check("ychain x kept", bus0.Xdisplay, 16'h0005);
    digits(16'h1, 1); press(K_EQ);
    check("ychain x", bus0.Xdisplay, 16'h000E);
    check("ychain neg", bus0.LED_NEG_digit, 1);

    // FFFF squared overflows: wrap vs saturate
    press(K_CA); digits(16'hFFFF, 4); press(K_SQR);
    check("sqr busy", bus0.busy, 1);
    repeat (W) @(negedge clk);
    check("sqr busy end", bus0.busy, 0);
    check("sqr x wrap", bus0.Xdisplay, 16'h0001);
    check("sqr ovw wrap", bus0.LED_OVW, 1);
    check("sqr neg", bus0.LED_NEG_digit, 0);
    check("sqr x sat", bus1.Xdisplay, 16'hFFFF);
    check("sqr ovw sat", bus1.LED_OVW, 1);
    press(K_CE);
    check("ce x", bus0.Xdisplay, 0);
    check("ce ovw", bus0.LED_OVW, 0);
    check("ce x sat", bus1.Xdisplay, 0);
    check("ce ovw sat", bus1.LED_OVW, 0);

    // reset while multiplying
    digits(16'hFFFF, 4); press(K_ADD); digits(16'h1, 1); press(K_EQ);
    digits(16'h5, 1); press(K_MPLUS);
    digits(16'h9, 1); press(K_MUL); digits(16'h9, 1); press(K_EQ);
    check("abort busy", bus0.busy, 1);
    press(5'h11); press(K_ADD);
    check("abort x held", bus0.Xdisplay, 16'h0009);
    check("abort busy held", bus0.busy, 1);
    check("abort ovw before", bus0.LED_OVW, 1);
    check("abort mem before", bus0.mem_valid, 1);
    rst = 1'b0;
    #1;
    check("abort x", bus0.Xdisplay, 0);
    check("abort neg", bus0.LED_NEG_digit, 0);
    check("abort ovw", bus0.LED_OVW, 0);
    check("abort busy", bus0.busy, 0);
    check("abort mem_valid", bus0.mem_valid, 0);
    check("abort busy sat", bus1.busy, 0);
    check("abort state sat", dbg1, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    check("post abort busy", bus0.busy, 0);
    check("post abort x", bus0.Xdisplay, 0);
    digits(16'h3, 1);
    check("post abort digit", bus0.Xdisplay, 16'h0003);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
